// File: rtl/axi_mem_responder.sv
// -----------------------------------------------------------------------------
// axi_mem_responder
//
// Simulation-side AXI4 slave memory model. It serves one read burst and one
// write burst at a time; the read and write channels are independent of each
// other. Storage is an array of 128-bit words with per-byte write enables.
// R and B responses echo the request ID. Beats that fall outside
// [MEM_BASE, MEM_BASE + 16*MEM_WORDS) return SLVERR (2'b10).
//
// Optional feature:
//   AXI_MEM_RD_LATENCY_EN - when defined, the first read beat of each burst is
//   delayed by a RWAIT state so that r_valid first rises 8 cycles after the AR
//   handshake instead of 1. Later beats of the burst are not delayed.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ar_*                  read address channel (valid/ready, addr, id, len, size)
//   aw_*                  write address channel (valid/ready, addr, id, len, size)
//   w_*                   write data channel (valid/ready, data, strb, last)
//   b_*                   write response channel (valid/ready, id, resp)
//   r_*                   read data channel (valid/ready, data, id, resp, last)
//   dbg_state             {read FSM state, write FSM state}, for observation only
//
// Handshake rule used on every channel: a transfer happens on a rising clk edge
// where both valid and ready are 1. Once this block raises a valid it keeps
// that valid and all payload stable until the transfer happens.
// -----------------------------------------------------------------------------
module axi_mem_responder #(
    parameter int                        AXI_ID_WIDTH   = 8,
    parameter int                        AXI_ADDR_WIDTH = 40,
    parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BASE       = 40'h1C000000,
    parameter int                        MEM_WORDS      = 65536
) (
    input  logic                      clk,
    input  logic                      reset,
    // read address channel
    input  logic                      ar_valid,
    output logic                      ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
    input  logic [AXI_ID_WIDTH-1:0]   ar_id,
    input  logic [7:0]                ar_len,
    input  logic [2:0]                ar_size,
    // write address channel
    input  logic                      aw_valid,
    output logic                      aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
    input  logic [AXI_ID_WIDTH-1:0]   aw_id,
    input  logic [7:0]                aw_len,
    input  logic [2:0]                aw_size,
    // write data channel
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [127:0]              w_data,
    input  logic [15:0]               w_strb,
    input  logic                      w_last,
    // write response channel
    output logic                      b_valid,
    input  logic                      b_ready,
    output logic [AXI_ID_WIDTH-1:0]   b_id,
    output logic [1:0]                b_resp,
    // read data channel
    output logic                      r_valid,
    input  logic                      r_ready,
    output logic [127:0]              r_data,
    output logic [AXI_ID_WIDTH-1:0]   r_id,
    output logic [1:0]                r_resp,
    output logic                      r_last,
    // state observation
    output logic [3:0]                dbg_state
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    // One past the last valid byte address; one extra bit so the sum cannot wrap.
    localparam logic [AXI_ADDR_WIDTH:0] MEM_END =
        {1'b0, MEM_BASE} + ((AXI_ADDR_WIDTH+1)'(MEM_WORDS) << 4);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // RD_WAIT is only reachable when AXI_MEM_RD_LATENCY_EN is defined.
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } wr_state_t;

    // -------------------------------------------------------------------------
    // Storage (never reset)
    // -------------------------------------------------------------------------
    logic [127:0] r_mem [MEM_WORDS];

    // -------------------------------------------------------------------------
    // Read channel registers
    // -------------------------------------------------------------------------
    rd_state_t                 r_rd_state;
    logic                      r_ar_ready;
    logic                      r_r_valid;
    logic [AXI_ID_WIDTH-1:0]   r_r_id;
    logic [AXI_ADDR_WIDTH-1:0] r_rd_base;
    logic [7:0]                r_rd_len;
    logic [2:0]                r_rd_size;
    logic [7:0]                r_rd_beat;
`ifdef AXI_MEM_RD_LATENCY_EN
    logic [3:0]                r_rd_wait_cnt;
`endif

    // -------------------------------------------------------------------------
    // Write channel registers
    // -------------------------------------------------------------------------
    wr_state_t                 r_wr_state;
    logic                      r_aw_ready;
    logic                      r_w_ready;
    logic                      r_b_valid;
    logic [AXI_ID_WIDTH-1:0]   r_b_id;
    logic [1:0]                r_b_resp;
    logic [AXI_ADDR_WIDTH-1:0] r_wr_base;
    logic [7:0]                r_wr_len;
    logic [2:0]                r_wr_size;
    // Nine bits so that beats past len+1 (up to 511) are still counted.
    logic [8:0]                r_wr_cnt;
    logic                      r_wr_err;

    // -------------------------------------------------------------------------
    // Address arithmetic
    // -------------------------------------------------------------------------
    logic [AXI_ADDR_WIDTH-1:0] w_ar_aligned;
    logic [AXI_ADDR_WIDTH-1:0] w_aw_aligned;
    logic [AXI_ADDR_WIDTH-1:0] w_rd_addr;
    logic [AXI_ADDR_WIDTH-1:0] w_wr_addr;
    logic [AXI_ADDR_WIDTH-1:0] w_rd_off;
    logic [AXI_ADDR_WIDTH-1:0] w_wr_off;
    logic [IDX_W-1:0]          w_rd_idx;
    logic [IDX_W-1:0]          w_wr_idx;
    logic                      w_rd_hit;
    logic                      w_wr_hit;
    logic                      w_wr_beat_ok;
    logic                      w_wr_ok;
    logic [8:0]                w_wr_cnt_next;
    logic                      w_mem_we;
    logic                      w_unused_bits;

    // INCR bursts start at the size-aligned address.
    assign w_ar_aligned = ar_addr & ~((AXI_ADDR_WIDTH'(1) << ar_size) - AXI_ADDR_WIDTH'(1));
    assign w_aw_aligned = aw_addr & ~((AXI_ADDR_WIDTH'(1) << aw_size) - AXI_ADDR_WIDTH'(1));

    // Current beat address = aligned start + beat * bytes-per-beat.
    assign w_rd_addr = r_rd_base + (AXI_ADDR_WIDTH'(r_rd_beat) << r_rd_size);
    assign w_wr_addr = r_wr_base + (AXI_ADDR_WIDTH'(r_wr_cnt) << r_wr_size);

    assign w_rd_off = w_rd_addr - MEM_BASE;
    assign w_wr_off = w_wr_addr - MEM_BASE;
    assign w_rd_idx = w_rd_off[IDX_W+3:4];
    assign w_wr_idx = w_wr_off[IDX_W+3:4];

    assign w_rd_hit = ({1'b0, w_rd_addr} >= {1'b0, MEM_BASE}) && ({1'b0, w_rd_addr} < MEM_END);
    assign w_wr_hit = ({1'b0, w_wr_addr} >= {1'b0, MEM_BASE}) && ({1'b0, w_wr_addr} < MEM_END);

    // Only the first len+1 beats of a write burst may land in memory.
    assign w_wr_beat_ok  = (r_wr_cnt <= {1'b0, r_wr_len});
    assign w_wr_ok       = w_wr_hit && w_wr_beat_ok;
    assign w_wr_cnt_next = (r_wr_cnt == 9'h1FF) ? r_wr_cnt : r_wr_cnt + 9'd1;

    // Gated with reset so a beat arriving during reset is discarded.
    assign w_mem_we = !reset && (r_wr_state == WR_DATA) && w_valid && r_w_ready && w_wr_ok;

    // Offset bits above the array depth and the byte-within-word bits do not
    // select a word; the range check already covers them.
    assign w_unused_bits = ^{w_rd_off[AXI_ADDR_WIDTH-1:IDX_W+4], w_rd_off[3:0],
                             w_wr_off[AXI_ADDR_WIDTH-1:IDX_W+4], w_wr_off[3:0]};

    // -------------------------------------------------------------------------
    // Memory write port. Strobed bytes only; a read of the same word in the
    // same cycle sees the old contents because the read port is combinational
    // off the registered array.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 16; b++) begin
                if (w_strb[b]) begin
                    r_mem[w_wr_idx][b*8 +: 8] <= w_data[b*8 +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read FSM: IDLE -> [RWAIT] -> RDATA -> IDLE
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state    <= RD_IDLE;
            r_ar_ready    <= 1'b0;
            r_r_valid     <= 1'b0;
            r_r_id        <= '0;
            r_rd_base     <= '0;
            r_rd_len      <= '0;
            r_rd_size     <= '0;
            r_rd_beat     <= '0;
`ifdef AXI_MEM_RD_LATENCY_EN
            r_rd_wait_cnt <= '0;
`endif
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    r_ar_ready <= 1'b1;
                    if (ar_valid && r_ar_ready) begin
                        r_ar_ready <= 1'b0;
                        r_r_id     <= ar_id;
                        r_rd_base  <= w_ar_aligned;
                        r_rd_len   <= ar_len;
                        r_rd_size  <= ar_size;
                        r_rd_beat  <= '0;
`ifdef AXI_MEM_RD_LATENCY_EN
                        r_rd_wait_cnt <= 4'd7;
                        r_rd_state    <= RD_WAIT;
`else
                        r_r_valid  <= 1'b1;
                        r_rd_state <= RD_DATA;
`endif
                    end
                end
`ifdef AXI_MEM_RD_LATENCY_EN
                RD_WAIT: begin
                    // Leaving on count 1 places the first r_valid 8 cycles
                    // after the AR handshake.
                    if (r_rd_wait_cnt == 4'd1) begin
                        r_rd_wait_cnt <= '0;
                        r_r_valid     <= 1'b1;
                        r_rd_state    <= RD_DATA;
                    end else begin
                        r_rd_wait_cnt <= r_rd_wait_cnt - 4'd1;
                    end
                end
`endif
                RD_DATA: begin
                    if (r_r_valid && r_ready) begin
                        if (r_rd_beat == r_rd_len) begin
                            r_r_valid  <= 1'b0;
                            r_ar_ready <= 1'b1;
                            r_rd_state <= RD_IDLE;
                        end else begin
                            r_rd_beat <= r_rd_beat + 8'd1;
                        end
                    end
                end
                default: begin
                    r_r_valid  <= 1'b0;
                    r_rd_state <= RD_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Write FSM: IDLE -> WDATA -> WRESP -> IDLE
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state <= WR_IDLE;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_id     <= '0;
            r_b_resp   <= RESP_OKAY;
            r_wr_base  <= '0;
            r_wr_len   <= '0;
            r_wr_size  <= '0;
            r_wr_cnt   <= '0;
            r_wr_err   <= 1'b0;
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    r_aw_ready <= 1'b1;
                    if (aw_valid && r_aw_ready) begin
                        r_aw_ready <= 1'b0;
                        r_w_ready  <= 1'b1;
                        r_b_id     <= aw_id;
                        r_wr_base  <= w_aw_aligned;
                        r_wr_len   <= aw_len;
                        r_wr_size  <= aw_size;
                        r_wr_cnt   <= '0;
                        r_wr_err   <= 1'b0;
                        r_wr_state <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_valid && r_w_ready) begin
                        r_wr_cnt <= w_wr_cnt_next;
                        if (!w_wr_ok) begin
                            r_wr_err <= 1'b1;
                        end
                        if (w_last) begin
                            r_w_ready <= 1'b0;
                            r_b_valid <= 1'b1;
                            // Fold in this beat's own error and the final count.
                            if (r_wr_err || !w_wr_ok ||
                                (w_wr_cnt_next != ({1'b0, r_wr_len} + 9'd1))) begin
                                r_b_resp <= RESP_SLVERR;
                            end else begin
                                r_b_resp <= RESP_OKAY;
                            end
                            r_wr_state <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (r_b_valid && b_ready) begin
                        r_b_valid  <= 1'b0;
                        r_aw_ready <= 1'b1;
                        r_wr_state <= WR_IDLE;
                    end
                end
                default: begin
                    r_w_ready  <= 1'b0;
                    r_b_valid  <= 1'b0;
                    r_wr_state <= WR_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Read payload is zero whenever r_valid is low so that the bus is
    // all-zero out of reset; it is a pure function of registered state, so it
    // holds stable across an r_ready stall.
    // -------------------------------------------------------------------------
    assign ar_ready  = r_ar_ready;
    assign aw_ready  = r_aw_ready;
    assign w_ready   = r_w_ready;
    assign b_valid   = r_b_valid;
    assign b_id      = r_b_id;
    assign b_resp    = r_b_resp;
    assign r_valid   = r_r_valid;
    assign r_id      = r_r_id;
    assign r_data    = (r_r_valid && w_rd_hit) ? r_mem[w_rd_idx] : 128'd0;
    assign r_resp    = (r_r_valid && !w_rd_hit) ? RESP_SLVERR : RESP_OKAY;
    assign r_last    = r_r_valid && (r_rd_beat == r_rd_len);
    assign dbg_state = {r_rd_state, r_wr_state};

endmodule
